// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits, decodes hex nibbles,
// leading-zero suppression, PWM brightness and frame-synchronous double buffering.
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESC_W        = 16,
    parameter int BR_W           = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] D,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   BLANK,
    input  logic                    LZS,
    input  logic                    LOAD,
    input  logic [BR_W-1:0]         BRIGHT,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   DIGIT,
    output logic                    FRAME
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] stg_d, act_d;
    logic [NUM_DIGITS-1:0]   stg_dp, act_dp, stg_blank, act_blank;

    logic                    tick, boundary, bright_en, upper_dark;
    logic [NUM_DIGITS-1:0]   suppress, digit_vec;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank, cur_supp;
    logic [7:0]              seg_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign tick     = &presc;
    assign boundary = tick && (idx == LAST_IDX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc     <= '0;
            idx       <= '0;
            stg_d     <= '0;
            stg_dp    <= '0;
            stg_blank <= '1;
            act_d     <= '0;
            act_dp    <= '0;
            act_blank <= '1;
        end else begin
            presc <= presc + 1'b1;
            if (tick)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (LOAD) begin
                stg_d     <= D;
                stg_dp    <= DP;
                stg_blank <= BLANK;
            end
            // Boundary copies the pre-edge staging, so a coincident LOAD lands one frame later.
            if (boundary) begin
                act_d     <= stg_d;
                act_dp    <= stg_dp;
                act_blank <= stg_blank;
            end
        end
    end

    always_comb begin
        bright_en  = (presc[PRESC_W-1 -: BR_W] < BRIGHT) || (&BRIGHT);
        upper_dark = 1'b1;
        suppress   = '0;
        digit_vec  = '0;
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_supp   = 1'b0;
        // Walk from the most significant digit down, tracking whether everything above is dark.
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (LZS && (k < NUM_DIGITS - 1) && upper_dark &&
                (act_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0))
                suppress[NUM_DIGITS-1-k] = 1'b1;
            upper_dark = upper_dark && ((act_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0) ||
                                        act_blank[NUM_DIGITS-1-k]);
        end
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = act_d[4*k +: 4];
                cur_dp    = act_dp[k];
                cur_blank = act_blank[k];
                cur_supp  = suppress[k];
            end
            digit_vec[k] = bright_en && (idx == IDX_W'(k));
        end
        seg_next = {cur_dp && !cur_blank,
                    (cur_blank || cur_supp) ? 7'h00 : decode(cur_nib)};
    end

    // FRAME is registered from the index-0/prescaler-0 state so it coincides with digit 0's first output cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SEG   <= {8{SEG_ACTIVE_LOW}};
            DIGIT <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            FRAME <= 1'b0;
        end else begin
            SEG   <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
            DIGIT <= DIG_ACTIVE_LOW ? ~digit_vec : digit_vec;
            FRAME <= (idx == '0) && (presc == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: arithmetic reference model driven by cycle count,
// directed scenarios plus randomized loads, and two extra instances for the parameter sweep.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d;
    logic [3:0]  dp, blank;
    logic        lzs, load;
    logic [1:0]  bright;
    logic [7:0]  seg;
    logic [3:0]  digit;
    logic        frame;

    logic [7:0]  seg1, seg8;
    logic [0:0]  digit1;
    logic [7:0]  digit8;
    logic        frame1, frame8;
    logic [31:0] d8 = 32'h8888_8888;
    logic [7:0]  zero8 = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: cycle count since reset plus the two data banks.
    int unsigned t;
    logic [15:0] m_sd, m_ad;
    logic [3:0]  m_sdp, m_adp, m_sb, m_ab;
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    seg_scan_mux #(.NUM_DIGITS(4), .PRESC_W(4), .BR_W(2),
                   .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
        .CLK(clk), .RST(rst), .D(d), .DP(dp), .BLANK(blank), .LZS(lzs),
        .LOAD(load), .BRIGHT(bright), .SEG(seg), .DIGIT(digit), .FRAME(frame));

    seg_scan_mux #(.NUM_DIGITS(1), .PRESC_W(4), .BR_W(2),
                   .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u1 (
        .CLK(clk), .RST(rst), .D(d[3:0]), .DP(dp[0]), .BLANK(blank[0]), .LZS(lzs),
        .LOAD(load), .BRIGHT(2'b11), .SEG(seg1), .DIGIT(digit1), .FRAME(frame1));

    seg_scan_mux #(.NUM_DIGITS(8), .PRESC_W(4), .BR_W(2),
                   .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) u8 (
        .CLK(clk), .RST(rst), .D(d8), .DP(zero8), .BLANK(zero8), .LZS(1'b0),
        .LOAD(load), .BRIGHT(2'b11), .SEG(seg8), .DIGIT(digit8), .FRAME(frame8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t     = 0;
        m_sd  = '0;
        m_ad  = '0;
        m_sdp = '0;
        m_adp = '0;
        m_sb  = '1;
        m_ab  = '1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        #1;
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_digit", {28'd0, digit}, 32'hF);
        chk("rst_frame", {31'd0, frame}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: predict the outputs from the pre-edge state, advance, then compare.
    task automatic step();
        int unsigned ix, pr;
        logic [3:0]  nib;
        logic        supp, dark, dpb, ef, ef1;
        logic [6:0]  s7;
        logic [7:0]  eseg;
        logic [3:0]  edig;
        ix   = (t / 16) % 4;
        pr   = t % 16;
        nib  = m_ad[ix*4 +: 4];
        supp = 1'b0;
        if (lzs && ix > 0 && nib == 4'h0) begin
            supp = 1'b1;
            for (int unsigned j = ix + 1; j < 4; j++)
                if (m_ad[j*4 +: 4] != 4'h0 && !m_ab[j]) supp = 1'b0;
        end
        dark = m_ab[ix] || supp;
        s7   = dark ? 7'h00 : seg_tab[nib];
        dpb  = m_adp[ix] && !m_ab[ix];
        eseg = ~{dpb, s7};
        edig = (bright == 2'd3 || (pr / 4) < bright) ? ~(4'b0001 << ix) : 4'hF;
        ef   = (t % 64 == 0);
        ef1  = (t % 16 == 0);
        @(posedge clk);
        #1;
        if (t % 64 == 63) begin
            m_ad  = m_sd;
            m_adp = m_sdp;
            m_ab  = m_sb;
        end
        if (load) begin
            m_sd  = d;
            m_sdp = dp;
            m_sb  = blank;
        end
        t++;
        chk("seg", {24'd0, seg}, {24'd0, eseg});
        chk("digit", {28'd0, digit}, {28'd0, edig});
        chk("frame", {31'd0, frame}, {31'd0, ef});
        chk("onehot", $countones(~digit) <= 1, 32'd1);
        chk("u1_digit", {31'd0, digit1}, 32'd0);
        chk("u1_frame", {31'd0, frame1}, {31'd0, ef1});
    endtask

    task automatic step_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic step_until_state(input int unsigned m);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 65; k++) begin
            if (t % 64 == m) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("until_state", {31'd0, found}, 32'd1);
    endtask

    // Leaves the outputs showing the first cycle of slot s.
    task automatic show_slot(input int unsigned s);
        step_until_state(s * 16);
        step();
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        d = '0; dp = '0; blank = '0; lzs = 1'b0; load = 1'b0; bright = 2'd3;
        do_reset();
        step();
        chk("u8_dark", {24'd0, seg8}, 32'h00);

        // Reset mid-scan, then stay dark without a LOAD.
        repeat (37) step();
        do_reset();
        repeat (100) step();
        chk("dark_after_rst", {24'd0, seg}, 32'hFF);

        // Basic decode across all four slots.
        d = 16'h12AF; dp = 4'h0; blank = 4'h0; bright = 2'd3;
        step_load();
        show_slot(0);
        chk("s0_seg", {24'd0, seg}, {24'd0, ~8'h71});
        chk("s0_dig", {28'd0, digit}, 32'hE);
        chk("s0_frame", {31'd0, frame}, 32'd1);
        show_slot(1);
        chk("s1_seg", {24'd0, seg}, {24'd0, ~8'h77});
        chk("s1_dig", {28'd0, digit}, 32'hD);
        show_slot(2);
        chk("s2_seg", {24'd0, seg}, {24'd0, ~8'h5B});
        chk("s2_dig", {28'd0, digit}, 32'hB);
        show_slot(3);
        chk("s3_seg", {24'd0, seg}, {24'd0, ~8'h06});
        chk("s3_dig", {28'd0, digit}, 32'h7);

        // LOAD coincident with the boundary tick.
        d = 16'h5555;
        step_until_state(63);
        step_load();
        show_slot(0);
        chk("coinc_old", {24'd0, seg}, {24'd0, ~8'h71});
        show_slot(0);
        chk("coinc_new", {24'd0, seg}, {24'd0, ~8'h6D});

        // Two LOADs in one frame: last wins.
        d = 16'h1111;
        step_load();
        repeat (10) step();
        d = 16'h2222;
        step_load();
        show_slot(0);
        chk("last_load", {24'd0, seg}, {24'd0, ~8'h5B});

        // Leading-zero suppression.
        lzs = 1'b1; d = 16'h0070; dp = 4'h0;
        step_load();
        show_slot(0);
        chk("lzs_d0", {24'd0, seg}, {24'd0, ~8'h3F});
        show_slot(1);
        chk("lzs_d1", {24'd0, seg}, {24'd0, ~8'h07});
        show_slot(2);
        chk("lzs_d2", {24'd0, seg}, 32'hFF);
        show_slot(3);
        chk("lzs_d3", {24'd0, seg}, 32'hFF);
        dp = 4'h8;
        step_load();
        show_slot(3);
        chk("lzs_dp3", {24'd0, seg}, 32'h7F);
        lzs = 1'b0; dp = 4'h0;

        // Brightness duty.
        begin
            int cnt;
            bright = 2'd1;
            step();
            cnt = 0;
            for (int k = 0; k < 64; k++) begin
                step();
                if (digit != 4'hF) cnt++;
            end
            chk("bright1_cnt", cnt, 32'd16);
            bright = 2'd0;
            step();
            cnt = 0;
            for (int k = 0; k < 64; k++) begin
                step();
                if (digit != 4'hF) cnt++;
            end
            chk("bright0_cnt", cnt, 32'd0);
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 25; it++) begin
            d      = 16'($urandom);
            dp     = 4'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lzs    = 1'($urandom);
            bright = 2'($urandom);
            if (it == 12) do_reset();
            if ($urandom_range(0, 3) != 0) step_load();
            repeat ($urandom_range(1, 80)) step();
            bright = 2'($urandom);
            lzs    = 1'($urandom);
            repeat ($urandom_range(1, 40)) step();
        end

        // 8-digit active-high instance showing all 8s.
        bright = 2'd3;
        step_load();
        repeat (140) step();
        chk("u8_seg", {24'd0, seg8}, 32'h7F);
        chk("u8_onehot", $countones(digit8), 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised multiplexed seven-segment display driver. It is the successor to the fixed 4-digit svn_seg. It scans NUM_DIGITS common-electrode digits and decodes hex nibbles, with per-digit decimal point and blanking, leading-zero suppression, PWM brightness, and frame-synchronous double-buffered updates. It sits between board-level SEG/DIGIT pins and any producer of display data, such as the I2C slave IO register or a counter.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..8)
PRESC_W, 16, prescaler width; one digit slot = 2^PRESC_W CLK cycles
BR_W, 3, brightness control width (PRESC_W >= BR_W)
SEG_ACTIVE_LOW, 1, 1 = SEG pins drive 0 to light a segment
DIG_ACTIVE_LOW, 1, 1 = DIGIT pins drive 0 to enable a digit

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
D  in  4*NUM_DIGITS  hex nibbles; digit i = D[4i+3:4i]; digit 0 is least significant/rightmost
DP  in  NUM_DIGITS  decimal point per digit, 1 = lit
BLANK  in  NUM_DIGITS  per-digit forced blank, 1 = digit dark (DP also dark)
LZS  in  1  leading-zero suppression enable (live input, not buffered)
LOAD  in  1  single-cycle strobe; capture D/DP/BLANK into staging
BRIGHT  in  BR_W  brightness; 0 = off, all-ones = full on
SEG  out  8  SEG[6:0] = segments g..a, SEG[7] = DP; polarity per SEG_ACTIVE_LOW
DIGIT  out  NUM_DIGITS  one-hot digit enable; polarity per DIG_ACTIVE_LOW
FRAME  out  1  one-cycle pulse at the start of each scan frame (digit 0 slot)

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset state:
  - Prescaler = 0, scan index = 0.
  - Staging and active registers: D = 0, DP = 0, BLANK = all ones.
  - SEG and DIGIT all inactive in their configured polarity. FRAME = 0.
  - The display stays dark until the first LOAD propagates.
- Prescaler: free-running PRESC_W-bit up-counter, wraps. Tick = prescaler all ones.
- Scan index: on each tick, index <= (index == NUM_DIGITS-1) ? 0 : index+1. Boundary = tick with index == NUM_DIGITS-1.
- Double buffer:
  - LOAD=1: staging <= {D, DP, BLANK} on that edge.
  - Boundary: active <= staging.
  - LOAD coincident with boundary: active takes the old staging; new data appears one frame later.
  - Multiple LOADs within a frame: last one wins.
- Leading-zero suppression (LZS=1): digit i (i>0) is blanked if its active nibble is 0 and all digits j>i have nibble 0 or active BLANK set. Digit 0 is never suppressed. A suppressed digit's DP still lights if set.
- Decode (active-high form, g..a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Brightness:
  - Digit enable = (prescaler[PRESC_W-1 -: BR_W] < BRIGHT) or (BRIGHT all ones).
  - BRIGHT = 0 means DIGIT is always inactive. SEG continues to be driven.
- Output registration:
  - SEG and DIGIT are registered: they reflect the index, prescaler and active state of the previous cycle (latency 1).
  - Exactly one DIGIT bit active when enabled, never more.
  - FRAME is registered high for the cycle after the boundary tick, aligned with the first SEG/DIGIT of digit 0.
- Reset mid-frame: all state returns to reset values immediately, asynchronously; the pending staging is discarded.
- BRIGHT and LZS are sampled live each cycle.

Test Plan:
Bench parameters: NUM_DIGITS=4, PRESC_W=4, BR_W=2, both ACTIVE_LOW=1.

1. Reset: assert RST mid-scan -> SEG=8'hFF and DIGIT=4'hF in the same cycle, FRAME=0. After release, stays dark until LOAD plus boundary.
2. LOAD D=16'h12AF, DP=0, BLANK=0, BRIGHT=3 -> from the next frame, slots 0..3 show SEG=~8'h71, ~8'h77, ~8'h5B, ~8'h06 with DIGIT=4'hE, D, B, 7. Each slot lasts 16 cycles; FRAME pulses every 64 cycles.
3. LOAD asserted on the boundary-tick cycle with D=16'h5555 -> the following frame shows the old data; 5s appear one frame later. Two LOADs in one frame -> only the second is displayed.
4. LZS=1, D=16'h0070 -> digits 3 and 2 dark, digit 1 = ~8'h07, digit 0 = ~8'h3F. With DP[3]=1 -> digit 3 shows SEG=8'h7F only.
5. BRIGHT=1 -> DIGIT active 4 of 16 cycles per slot (prescaler 0..3, shifted by 1-cycle latency). BRIGHT=0 -> DIGIT=4'hF throughout.
6. Param sweep NUM_DIGITS=1 and 8, SEG_ACTIVE_LOW=0 -> 1-digit: DIGIT constantly enabled, FRAME every 16 cycles. Active-high: SEG for '8' = 8'h7F. One-hot DIGIT checked by assertion.
